// File: rtl/pb_debounce_pkg.sv
// Shared encodings and board defaults for the pushbutton debouncer.
package pb_debounce_pkg;

  localparam logic [1:0] S_LOW  = 2'd0;
  localparam logic [1:0] S_RISE = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_FALL = 2'd3;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_CNT_W           = 20;

endpackage

// File: rtl/pb_debounce_chan.sv
// One button channel: two-flop synchronizer, polarity fix, stability FSM with
// registered level and one-cycle press/release pulses.
module pb_debounce_chan
  import pb_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned ACTIVE_LOW      = 0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pb_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic             RAW_IDLE = (ACTIVE_LOW != 0);

  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             w_s;

  assign w_s = r_sync2 ^ RAW_IDLE;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // Sync flops hold the raw not-pressed level so reset never looks like a press.
      r_sync1   <= RAW_IDLE;
      r_sync2   <= RAW_IDLE;
      r_state   <= S_LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_pb_raw;
      r_sync2   <= r_sync1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        S_LOW: begin
          if (w_s) begin
            r_state <= S_RISE;
            r_cnt   <= '0;
          end
        end
        S_RISE: begin
          if (!w_s) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (!w_s) begin
            r_state <= S_FALL;
            r_cnt   <= '0;
          end
        end
        S_FALL: begin
          if (w_s) begin
            r_state <= S_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state   <= S_LOW;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/pb_debounce.sv
// Array of independent pushbutton debouncers feeding the button logic bus.
module pb_debounce
  import pb_debounce_pkg::*;
#(
  parameter int unsigned N_BTN           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W,
  parameter int unsigned ACTIVE_LOW      = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_BTN-1:0] PB_RAW,
  output logic [N_BTN-1:0] BTN_LEVEL,
  output logic [N_BTN-1:0] BTN_PRESS,
  output logic [N_BTN-1:0] BTN_RELEASE
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    pb_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_chan (
      .i_clk     (CLK),
      .i_rst_n   (RST_N),
      .i_pb_raw  (PB_RAW[g]),
      .o_level   (BTN_LEVEL[g]),
      .o_press   (BTN_PRESS[g]),
      .o_release (BTN_RELEASE[g])
    );
  end

endmodule

// File: tb/tb_pb_debounce.sv
// Directed bench for pb_debounce with an 8-cycle debounce window.
module tb_pb_debounce;

  logic       clk;
  logic       rst_n;
  logic [1:0] pb_raw;
  logic [1:0] btn_level;
  logic [1:0] btn_press;
  logic [1:0] btn_release;

  int n_total = 0;
  int n_bad   = 0;

  pb_debounce #(
    .N_BTN           (2),
    .DEBOUNCE_CYCLES (8),
    .CNT_W           (4),
    .ACTIVE_LOW      (0)
  ) u_dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .PB_RAW      (pb_raw),
    .BTN_LEVEL   (btn_level),
    .BTN_PRESS   (btn_press),
    .BTN_RELEASE (btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] lvl, input logic [1:0] prs,
                          input logic [1:0] rel);
    chk({tag, ".level"}, 32'(btn_level), 32'(lvl));
    chk({tag, ".press"}, 32'(btn_press), 32'(prs));
    chk({tag, ".release"}, 32'(btn_release), 32'(rel));
  endtask

  initial begin
    rst_n  = 1'b0;
    pb_raw = 2'b11;

    // 1: held through reset, accepted after full latency once reset lifts
    repeat (3) step();
    chk_outs("rst", 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i < 11)       chk_outs("rst_wait", 2'b00, 2'b00, 2'b00);
      else if (i == 11) chk_outs("rst_press", 2'b11, 2'b11, 2'b00);
      else              chk_outs("rst_after", 2'b11, 2'b00, 2'b00);
    end
    pb_raw = 2'b00;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i < 11)       chk_outs("rel_wait", 2'b11, 2'b00, 2'b00);
      else if (i == 11) chk_outs("rel_both", 2'b00, 2'b00, 2'b11);
      else              chk_outs("rel_after", 2'b00, 2'b00, 2'b00);
    end

    // 2: clean press on channel 0
    pb_raw = 2'b01;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk_outs("press0", (i >= 11) ? 2'b01 : 2'b00, (i == 11) ? 2'b01 : 2'b00, 2'b00);
    end

    // 4: short release glitch is rejected, then a held release is accepted
    pb_raw = 2'b00;
    for (int i = 1; i <= 16; i++) begin
      if (i == 6) pb_raw = 2'b01;
      step();
      chk_outs("glitch0", 2'b01, 2'b00, 2'b00);
    end
    pb_raw = 2'b00;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_outs("release0", (i >= 11) ? 2'b00 : 2'b01, 2'b00, (i == 11) ? 2'b01 : 2'b00);
    end

    // 3: channel 1 bouncing every 3 cycles never settles long enough
    for (int i = 0; i < 30; i++) begin
      pb_raw = ((i / 3) % 2 == 0) ? 2'b10 : 2'b00;
      step();
      chk_outs("bounce1", 2'b00, 2'b00, 2'b00);
    end
    pb_raw = 2'b00;
    for (int i = 0; i < 14; i++) begin
      step();
      chk_outs("bounce1_tail", 2'b00, 2'b00, 2'b00);
    end

    // 5: simultaneous press on both channels
    pb_raw = 2'b11;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_outs("simul", (i >= 11) ? 2'b11 : 2'b00, (i == 11) ? 2'b11 : 2'b00, 2'b00);
    end
    pb_raw = 2'b10;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_outs("rel0_only", (i >= 11) ? 2'b10 : 2'b11, 2'b00, (i == 11) ? 2'b01 : 2'b00);
    end

    // 6: reset mid-debounce on ch0 (ch1 held high) clears everything, then full latency
    pb_raw = 2'b11;
    repeat (7) step();
    chk_outs("pre_rst", 2'b10, 2'b00, 2'b00);
    rst_n = 1'b0;
    step();
    chk_outs("mid_rst", 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_outs("post_rst", (i >= 11) ? 2'b11 : 2'b00, (i == 11) ? 2'b11 : 2'b00, 2'b00);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
